// File: rtl/mano_pkg.sv
// Shared definitions for the basic-computer datapath and its control unit.
// Holds bus/ALU codes, control-word bit positions and width constants.
package mano_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 12;
  localparam int CW_W   = 17;

  localparam int CW_AR_LD   = 16;
  localparam int CW_PC_LD   = 15;
  localparam int CW_PC_INR  = 14;
  localparam int CW_DR_LD   = 13;
  localparam int CW_DR_INR  = 12;
  localparam int CW_AC_LD   = 11;
  localparam int CW_AC_CLR  = 10;
  localparam int CW_IR_LD   = 9;
  localparam int CW_TR_LD   = 8;
  localparam int CW_E_CLR   = 7;
  localparam int CW_ALU_LSB = 4;
  localparam int CW_MEM_WR  = 3;
  localparam int CW_BUS_LSB = 0;

  typedef enum logic [2:0] {
    BUS_ZERO = 3'b000,
    BUS_AR   = 3'b001,
    BUS_PC   = 3'b010,
    BUS_DR   = 3'b011,
    BUS_AC   = 3'b100,
    BUS_IR   = 3'b101,
    BUS_TR   = 3'b110,
    BUS_MEM  = 3'b111
  } bus_sel_e;

  typedef enum logic [2:0] {
    ALU_HOLD = 3'b000,
    ALU_AND  = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_LDR  = 3'b011,
    ALU_CMA  = 3'b100,
    ALU_CIR  = 3'b101,
    ALU_CIL  = 3'b110,
    ALU_INC  = 3'b111
  } alu_op_e;

  // Control words that ask two sources to drive one destination, or that
  // read and write memory through the same bus in one cycle.
  function automatic logic illegal_cw(input logic [CW_W-1:0] cw);
    return (cw[CW_MEM_WR] && (cw[CW_BUS_LSB +: 3] == BUS_MEM)) ||
           (cw[CW_PC_LD] && cw[CW_PC_INR]) ||
           (cw[CW_DR_LD] && cw[CW_DR_INR]) ||
           (cw[CW_AC_LD] && cw[CW_AC_CLR]);
  endfunction

endpackage

// File: rtl/mano_alu.sv
// Combinational accumulator ALU: logic, add, complement, rotates through E
// and increment. e_next equals e for operations that leave E alone.
module mano_alu
  import mano_pkg::*;
(
  input  logic [WORD_W-1:0] ac,
  input  logic [WORD_W-1:0] dr,
  input  logic              e,
  input  alu_op_e           alu_op,
  output logic [WORD_W-1:0] result,
  output logic              e_next
);

  logic [WORD_W:0] add_sum;
  logic [WORD_W:0] inc_sum;

  assign add_sum = {1'b0, ac} + {1'b0, dr};
  assign inc_sum = {1'b0, ac} + {{WORD_W{1'b0}}, 1'b1};

  always_comb begin
    result = ac;
    e_next = e;
    case (alu_op)
      ALU_HOLD: result = ac;
      ALU_AND:  result = ac & dr;
      ALU_ADD: begin
        result = add_sum[WORD_W-1:0];
        e_next = add_sum[WORD_W];
      end
      ALU_LDR:  result = dr;
      ALU_CMA:  result = ~ac;
      ALU_CIR: begin
        result = {e, ac[WORD_W-1:1]};
        e_next = ac[0];
      end
      ALU_CIL: begin
        result = {ac[WORD_W-2:0], e};
        e_next = ac[WORD_W-1];
      end
      ALU_INC: begin
        result = inc_sum[WORD_W-1:0];
        e_next = inc_sum[WORD_W];
      end
      default: result = ac;
    endcase
  end

endmodule

// File: rtl/mano_datapath.sv
// Basic-computer register/bus datapath with 4096x16 memory.
// Define MANO_DP_CHECK_EN to build the sticky illegal-control-word flag err.
module mano_datapath
  import mano_pkg::*;
#(
  parameter int MEM_DEPTH = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CW_W-1:0]   control_mem,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [WORD_W-1:0] prog_data,
  output logic [2:0]        opcode,
  output logic              i_bit,
  output logic [WORD_W-1:0] ac,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] ar,
  output logic              e,
  output logic [WORD_W-1:0] bus,
  output logic              err
);

  logic ar_ld, pc_ld, pc_inr, dr_ld, dr_inr, ac_ld, ac_clr;
  logic ir_ld, tr_ld, e_clr, mem_wr;
  alu_op_e  alu_op;
  bus_sel_e bus_sel;

  assign ar_ld   = control_mem[CW_AR_LD];
  assign pc_ld   = control_mem[CW_PC_LD];
  assign pc_inr  = control_mem[CW_PC_INR];
  assign dr_ld   = control_mem[CW_DR_LD];
  assign dr_inr  = control_mem[CW_DR_INR];
  assign ac_ld   = control_mem[CW_AC_LD];
  assign ac_clr  = control_mem[CW_AC_CLR];
  assign ir_ld   = control_mem[CW_IR_LD];
  assign tr_ld   = control_mem[CW_TR_LD];
  assign e_clr   = control_mem[CW_E_CLR];
  assign mem_wr  = control_mem[CW_MEM_WR];
  assign alu_op  = alu_op_e'(control_mem[CW_ALU_LSB +: 3]);
  assign bus_sel = bus_sel_e'(control_mem[CW_BUS_LSB +: 3]);

  logic [ADDR_W-1:0] ar_reg, pc_reg;
  logic [WORD_W-1:0] dr_reg, ac_reg, ir_reg, tr_reg;
  logic              e_reg;
  logic [WORD_W-1:0] mem [MEM_DEPTH];

  logic [WORD_W-1:0] alu_result;
  logic              alu_e;

  mano_alu u_alu (
    .ac     (ac_reg),
    .dr     (dr_reg),
    .e      (e_reg),
    .alu_op (alu_op),
    .result (alu_result),
    .e_next (alu_e)
  );

  always_comb begin
    bus = '0;
    case (bus_sel)
      BUS_ZERO: bus = '0;
      BUS_AR:   bus = {{(WORD_W-ADDR_W){1'b0}}, ar_reg};
      BUS_PC:   bus = {{(WORD_W-ADDR_W){1'b0}}, pc_reg};
      BUS_DR:   bus = dr_reg;
      BUS_AC:   bus = ac_reg;
      BUS_IR:   bus = ir_reg;
      BUS_TR:   bus = tr_reg;
      BUS_MEM:  bus = mem[ar_reg];
      default:  bus = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_reg <= '0;
      pc_reg <= '0;
      dr_reg <= '0;
      ac_reg <= '0;
      ir_reg <= '0;
      tr_reg <= '0;
      e_reg  <= 1'b0;
    end else begin
      if (ar_ld) ar_reg <= bus[ADDR_W-1:0];

      if (pc_ld)       pc_reg <= bus[ADDR_W-1:0];
      else if (pc_inr) pc_reg <= pc_reg + 1'b1;

      if (dr_ld)       dr_reg <= bus;
      else if (dr_inr) dr_reg <= dr_reg + 1'b1;

      if (ac_clr)     ac_reg <= '0;
      else if (ac_ld) ac_reg <= alu_result;

      // E follows the ALU only when the ALU result actually lands in AC.
      if (e_clr)                 e_reg <= 1'b0;
      else if (ac_ld && !ac_clr) e_reg <= alu_e;

      if (ir_ld) ir_reg <= bus;
      if (tr_ld) tr_reg <= bus;
    end
  end

  // Loader port wins; datapath writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (prog_we)
      mem[prog_addr] <= prog_data;
    else if (mem_wr && !reset)
      mem[ar_reg] <= bus;
  end

`ifdef MANO_DP_CHECK_EN
  logic err_reg;
  always_ff @(posedge clk) begin
    if (reset)
      err_reg <= 1'b0;
    else if (illegal_cw(control_mem))
      err_reg <= 1'b1;
  end
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign ac     = ac_reg;
  assign pc     = pc_reg;
  assign ar     = ar_reg;
  assign e      = e_reg;
  assign opcode = ir_reg[14:12];
  assign i_bit  = ir_reg[15];

endmodule

// File: tb/tb_mano_datapath.sv
// Self-checking bench for mano_datapath: directed steps then random control
// words, all checked against a behavioural model of registers and memory.
module tb_mano_datapath;

  localparam logic [16:0] C_AR_LD  = 17'h10000;
  localparam logic [16:0] C_PC_LD  = 17'h08000;
  localparam logic [16:0] C_PC_INR = 17'h04000;
  localparam logic [16:0] C_DR_LD  = 17'h02000;
  localparam logic [16:0] C_AC_LD  = 17'h00800;
  localparam logic [16:0] C_AC_CLR = 17'h00400;
  localparam logic [16:0] C_IR_LD  = 17'h00200;
  localparam logic [16:0] C_TR_LD  = 17'h00100;
  localparam logic [16:0] C_MEM_WR = 17'h00008;
  localparam logic [16:0] OP_ADD   = 17'h00020;
  localparam logic [16:0] OP_LDR   = 17'h00030;
  localparam logic [16:0] OP_CIR   = 17'h00050;
  localparam logic [16:0] OP_INC   = 17'h00070;
  localparam logic [16:0] S_PC     = 17'h00002;
  localparam logic [16:0] S_DR     = 17'h00003;
  localparam logic [16:0] S_AC     = 17'h00004;
  localparam logic [16:0] S_IR     = 17'h00005;
  localparam logic [16:0] S_MEM    = 17'h00007;

  logic        clk;
  logic        reset;
  logic [16:0] control_mem;
  logic        prog_we;
  logic [11:0] prog_addr;
  logic [15:0] prog_data;
  logic [2:0]  opcode;
  logic        i_bit;
  logic [15:0] ac;
  logic [11:0] pc;
  logic [11:0] ar;
  logic        e;
  logic [15:0] bus;
  logic        err;

  mano_datapath dut (
    .clk         (clk),
    .reset       (reset),
    .control_mem (control_mem),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .opcode      (opcode),
    .i_bit       (i_bit),
    .ac          (ac),
    .pc          (pc),
    .ar          (ar),
    .e           (e),
    .bus         (bus),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [11:0] m_ar, m_pc;
  logic [15:0] m_dr, m_ac, m_ir, m_tr;
  logic        m_e, m_err;
  logic [15:0] m_mem [4096];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_bus(input logic [2:0] sel);
    case (sel)
      3'd1:    return {4'h0, m_ar};
      3'd2:    return {4'h0, m_pc};
      3'd3:    return m_dr;
      3'd4:    return m_ac;
      3'd5:    return m_ir;
      3'd6:    return m_tr;
      3'd7:    return m_mem[m_ar];
      default: return 16'h0000;
    endcase
  endfunction

  task automatic cycle(input logic [16:0] cw, input logic pwe, input logic [11:0] pa,
                       input logic [15:0] pd, input logic rst);
    logic [15:0] v;
    int          s;
    logic [11:0] n_ar, n_pc;
    logic [15:0] n_dr, n_ac, n_ir, n_tr;
    logic        n_e, n_err;
    control_mem = cw;
    prog_we     = pwe;
    prog_addr   = pa;
    prog_data   = pd;
    reset       = rst;
    v = model_bus(cw[2:0]);
    #1;
    chk("bus", bus, v);
    n_ar = m_ar; n_pc = m_pc; n_dr = m_dr; n_ac = m_ac;
    n_ir = m_ir; n_tr = m_tr; n_e = m_e; n_err = m_err;
    if (rst) begin
      n_ar = '0; n_pc = '0; n_dr = '0; n_ac = '0;
      n_ir = '0; n_tr = '0; n_e = 1'b0; n_err = 1'b0;
    end else begin
      if (cw[16]) n_ar = v[11:0];
      if (cw[15])      n_pc = v[11:0];
      else if (cw[14]) n_pc = 12'((int'(m_pc) + 1) % 4096);
      if (cw[13])      n_dr = v;
      else if (cw[12]) n_dr = 16'((int'(m_dr) + 1) % 65536);
      if (cw[10]) n_ac = 16'h0000;
      else if (cw[11]) begin
        case (cw[6:4])
          3'd1: n_ac = m_ac & m_dr;
          3'd2: begin
            s = int'(m_ac) + int'(m_dr);
            n_ac = 16'(s % 65536);
            n_e = (s > 65535);
          end
          3'd3: n_ac = m_dr;
          3'd4: n_ac = 16'(65535 - int'(m_ac));
          3'd5: begin
            n_ac = 16'(int'(m_ac) / 2 + (m_e ? 32768 : 0));
            n_e = (int'(m_ac) % 2 == 1);
          end
          3'd6: begin
            n_ac = 16'((int'(m_ac) * 2 + (m_e ? 1 : 0)) % 65536);
            n_e = (int'(m_ac) >= 32768);
          end
          3'd7: begin
            s = int'(m_ac) + 1;
            n_ac = 16'(s % 65536);
            n_e = (s > 65535);
          end
          default: n_ac = m_ac;
        endcase
      end
      if (cw[7]) n_e = 1'b0;
      if (cw[9]) n_ir = v;
      if (cw[8]) n_tr = v;
`ifdef MANO_DP_CHECK_EN
      if ((cw[3] && cw[2:0] == 3'd7) || (cw[15] && cw[14]) ||
          (cw[13] && cw[12]) || (cw[11] && cw[10]))
        n_err = 1'b1;
`endif
    end
    if (pwe) m_mem[pa] = pd;
    else if (cw[3] && !rst) m_mem[m_ar] = v;
    m_ar = n_ar; m_pc = n_pc; m_dr = n_dr; m_ac = n_ac;
    m_ir = n_ir; m_tr = n_tr; m_e = n_e; m_err = n_err;
    @(posedge clk);
    #1;
    chk("ar", {4'h0, ar}, {4'h0, m_ar});
    chk("pc", {4'h0, pc}, {4'h0, m_pc});
    chk("ac", ac, m_ac);
    chk("e", {15'h0, e}, {15'h0, m_e});
    chk("opcode", {13'h0, opcode}, {13'h0, m_ir[14:12]});
    chk("i_bit", {15'h0, i_bit}, {15'h0, m_ir[15]});
    chk("err", {15'h0, err}, {15'h0, m_err});
  endtask

  task automatic step(input logic [16:0] cw);
    cycle(cw, 1'b0, 12'h000, 16'h0000, 1'b0);
  endtask

  task automatic prog(input logic [11:0] a, input logic [15:0] d);
    cycle(17'h0, 1'b1, a, d, 1'b0);
  endtask

  task automatic do_reset(input logic [16:0] cw);
    cycle(cw, 1'b0, 12'h000, 16'h0000, 1'b1);
  endtask

  // Puts v in M[AR] and loads it into the registers selected by ld.
  task automatic load(input logic [16:0] ld, input logic [15:0] v);
    prog(m_ar, v);
    step(ld | S_MEM);
  endtask

  task automatic bus_chk(input logic [16:0] sel, input logic [15:0] exp, input string tag);
    control_mem = sel;
    prog_we     = 1'b0;
    reset       = 1'b0;
    #1;
    chk(tag, bus, exp);
    step(sel);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_ar = '0; m_pc = '0; m_dr = '0; m_ac = '0;
    m_ir = '0; m_tr = '0; m_e = 1'b0; m_err = 1'b0;
    control_mem = '0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; reset = 1'b1;
    #1;
    do_reset(17'h0);
    for (int i = 0; i < 4096; i++) prog(12'(i), 16'($urandom));

    // Reset clears every register; memory survives
    load(C_PC_LD, 16'h0ABC);
    load(C_DR_LD, 16'hFFFF);
    step(C_AC_LD | OP_LDR);
    step(C_AC_LD | OP_INC);
    load(C_IR_LD | C_TR_LD, 16'hF123);
    load(C_DR_LD, 16'hBEEF);
    load(C_AR_LD, 16'h0777);
    prog(12'h777, 16'h1234);
    chk("pre_reset_e", {15'h0, e}, 16'h0001);
    do_reset(17'h1FFFF);
    chk("rst_ar", {4'h0, ar}, 16'h0000);
    chk("rst_pc", {4'h0, pc}, 16'h0000);
    chk("rst_ac", ac, 16'h0000);
    chk("rst_e", {15'h0, e}, 16'h0000);
    chk("rst_err", {15'h0, err}, 16'h0000);
    chk("rst_opcode", {13'h0, opcode}, 16'h0000);
    bus_chk(S_DR, 16'h0000, "rst_dr");
    bus_chk(S_IR, 16'h0000, "rst_ir");
    bus_chk(17'h00006, 16'h0000, "rst_tr");
    load(C_AR_LD, 16'h0777);
    bus_chk(S_MEM, 16'h1234, "mem_kept");

    // Fetch
    do_reset(17'h0);
    prog(12'h000, 16'h2005);
    step(C_AR_LD | S_PC);
    step(C_IR_LD | C_PC_INR | S_MEM);
    step(C_AR_LD | S_IR);
    bus_chk(S_IR, 16'h2005, "fetch_ir");
    chk("fetch_opcode", {13'h0, opcode}, 16'h0002);
    chk("fetch_i_bit", {15'h0, i_bit}, 16'h0000);
    chk("fetch_pc", {4'h0, pc}, 16'h0001);
    chk("fetch_ar", {4'h0, ar}, 16'h0005);

    // ADD with carry
    load(C_DR_LD, 16'h8000);
    step(C_AC_LD | OP_LDR);
    prog(12'h005, 16'h8001);
    step(C_DR_LD | S_MEM);
    step(C_AC_LD | OP_ADD);
    chk("add_ac", ac, 16'h0001);
    chk("add_e", {15'h0, e}, 16'h0001);

    // Rotate right through E, then store
    load(C_DR_LD, 16'h0003);
    step(C_AC_LD | OP_LDR);
    step(C_AC_LD | OP_CIR);
    chk("cir_ac", ac, 16'h8001);
    chk("cir_e", {15'h0, e}, 16'h0001);
    load(C_AR_LD, 16'h000A);
    step(C_MEM_WR | S_AC);
    bus_chk(S_MEM, 16'h8001, "store_mem");

    // PC wrap and priorities
    load(C_PC_LD, 16'h0FFF);
    step(C_PC_INR);
    chk("pc_wrap", {4'h0, pc}, 16'h0000);
    prog(m_ar, 16'h0123);
    step(C_PC_LD | C_PC_INR | S_MEM);
    chk("pc_ld_prio", {4'h0, pc}, 16'h0123);
    cycle(C_MEM_WR | S_AC, 1'b1, 12'h00A, 16'hC0DE, 1'b0);
    bus_chk(S_MEM, 16'hC0DE, "prog_prio");

`ifdef MANO_DP_CHECK_EN
    do_reset(17'h0);
    chk("err_clear", {15'h0, err}, 16'h0000);
    step(C_AC_LD | C_AC_CLR | OP_INC);
    chk("clr_prio_ac", ac, 16'h0000);
    chk("err_set", {15'h0, err}, 16'h0001);
    for (int i = 0; i < 3; i++) step(17'h0);
    chk("err_sticky", {15'h0, err}, 16'h0001);
    do_reset(17'h0);
    chk("err_reset", {15'h0, err}, 16'h0000);
`else
    step(C_AC_LD | C_AC_CLR | OP_INC);
    chk("clr_prio_ac", ac, 16'h0000);
    chk("err_tied", {15'h0, err}, 16'h0000);
`endif

    // Random control words against the model
    for (int i = 0; i < 600; i++) begin
      cycle(17'($urandom_range(0, 131071)),
            ($urandom_range(0, 7) == 0),
            12'($urandom_range(0, 4095)),
            16'($urandom),
            ($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
